// File: rtl/wb_split_pkg.sv
// ---------------------------------------------------------------------------
// wb_split_pkg
// Shared definitions for the Wishbone 1-to-N splitter.
//   state_e       : splitter FSM state encoding (IDLE, WAIT, RESP)
//   DEF_BAD_DATA  : default read data returned for an unmapped slave index
//   DEF_TMO_DATA  : default read data returned when a slave times out
//   ERR_CNT_MAX   : saturation value of the error counter
// ---------------------------------------------------------------------------
package wb_split_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] DEF_BAD_DATA = 32'hDEADBEEF;
  localparam logic [31:0] DEF_TMO_DATA = 32'hBADC0FFE;
  localparam logic [15:0] ERR_CNT_MAX  = 16'hFFFF;

endpackage

// File: rtl/wb_split_tmo.sv
// ---------------------------------------------------------------------------
// wb_split_tmo
// Slave response timeout counter. It counts cycles while enabled, starting
// from 0. It flags expiry in the (2^W-1)-th enabled cycle, so a slave gets
// exactly 2^W-1 cycles to answer.
// Only built when WB_SPLIT_TMO_EN is defined.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   en_i       : count this cycle (splitter is waiting on a slave)
//   clr_i      : return the count to 0
//   expired_o  : the current enabled cycle is the last allowed one
// ---------------------------------------------------------------------------
module wb_split_tmo #(
  parameter int W = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  // 2^W-2 is the count seen in the (2^W-1)-th enabled cycle
  localparam logic [W-1:0] LAST = ~W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = en_i && (count_q == LAST);

endmodule

// File: rtl/wb_split_n.sv
// ---------------------------------------------------------------------------
// wb_split_n
// Wishbone 1-to-N address splitter. The 4-bit field
// wbs_adr_i[SEL_LSB+3:SEL_LSB] selects one of NSLV downstream slaves. An
// unmapped index is answered locally with BAD_DATA and counted as an error.
// Optional feature: define WB_SPLIT_TMO_EN to add a slave response timeout.
// The timeout answers with TMO_DATA and also counts as an error.
// Ports
//   wb_clk_i, wb_rst_i          : clock, synchronous active-high reset
//   wbs_cyc/stb/we/sel/adr/dat_i : upstream request
//   wbs_ack_o, wbs_dat_o         : upstream response (ack lasts one cycle)
//   s_cyc_o, s_stb_o             : per-slave one-hot strobes
//   s_we/sel/adr/dat_o           : shared request fields (pass-through)
//   s_ack_i, s_dat_i             : per-slave ack and read data (32b/slave)
//   err_cnt_o, err_irq_o         : saturating error count, error pulse
// ---------------------------------------------------------------------------
module wb_split_n
  import wb_split_pkg::*;
#(
  parameter int          NSLV     = 3,
  parameter int          SEL_LSB  = 16,
  parameter int          TMO_W    = 8,
  parameter logic [31:0] BAD_DATA = DEF_BAD_DATA,
  parameter logic [31:0] TMO_DATA = DEF_TMO_DATA
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic [NSLV-1:0]    s_cyc_o,
  output logic [NSLV-1:0]    s_stb_o,
  output logic               s_we_o,
  output logic [3:0]         s_sel_o,
  output logic [31:0]        s_adr_o,
  output logic [31:0]        s_dat_o,
  input  logic [NSLV-1:0]    s_ack_i,
  input  logic [NSLV*32-1:0] s_dat_i,
  output logic [15:0]        err_cnt_o,
  output logic               err_irq_o
);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic        errFlag_q, errFlag_d;
  logic [15:0] errCnt_q, errCnt_d;

  logic [3:0]  reqIdx;
  logic        reqValid;
  logic        selAck;
  logic [31:0] selData;
  logic        raiseErr;
  logic        tmoExpired;

  assign reqIdx   = wbs_adr_i[SEL_LSB+3:SEL_LSB];
  assign reqValid = {1'b0, reqIdx} < 5'(NSLV);

`ifdef WB_SPLIT_TMO_EN
  // Count only while waiting on a slave; any other state restarts the count.
  wb_split_tmo #(
    .W (TMO_W)
  ) u_tmo (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .en_i      (state_q == ST_WAIT),
    .clr_i     (state_q != ST_WAIT),
    .expired_o (tmoExpired)
  );
`else
  // No timeout hardware in this build. The expression is constant false.
  assign tmoExpired = (TMO_W < 0);
`endif

  // Choose the ack and read data of the addressed slave. Acks from the
  // other ports never reach the FSM.
  always_comb begin
    selAck  = 1'b0;
    selData = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (idx_q == 4'(k)) begin
        selAck  = s_ack_i[k];
        selData = s_dat_i[k*32 +: 32];
      end
    end
  end

  // One-hot strobes, active only while waiting on the addressed slave
  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    for (int k = 0; k < NSLV; k++) begin
      if ((state_q == ST_WAIT) && (idx_q == 4'(k))) begin
        s_cyc_o[k] = 1'b1;
        s_stb_o[k] = 1'b1;
      end
    end
  end

  assign s_we_o  = wbs_we_i;
  assign s_sel_o = wbs_sel_i;
  assign s_adr_o = wbs_adr_i;
  assign s_dat_o = wbs_dat_i;

  // FSM next state. Priority in WAIT: an upstream abort first, then the
  // slave ack, then the timeout. An ack in the expiry cycle therefore wins.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    errFlag_d = errFlag_q;
    raiseErr  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        errFlag_d = 1'b0;
        if (wbs_cyc_i && wbs_stb_i) begin
          if (reqValid) begin
            idx_d   = reqIdx;
            state_d = ST_WAIT;
          end else begin
            data_d    = BAD_DATA;
            errFlag_d = 1'b1;
            raiseErr  = 1'b1;
            state_d   = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else if (selAck) begin
          data_d    = selData;
          errFlag_d = 1'b0;
          state_d   = ST_RESP;
        end else if (tmoExpired) begin
          data_d    = TMO_DATA;
          errFlag_d = 1'b1;
          raiseErr  = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Error counter. The count is updated when entering RESP, so it already
  // includes the error during the error's ack cycle.
  always_comb begin
    errCnt_d = errCnt_q;
    if (raiseErr && (errCnt_q != ERR_CNT_MAX)) begin
      errCnt_d = errCnt_q + 16'd1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      errFlag_q <= 1'b0;
      errCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      errFlag_q <= errFlag_d;
      errCnt_q  <= errCnt_d;
    end
  end

  assign wbs_ack_o = (state_q == ST_RESP);
  assign wbs_dat_o = data_q;
  assign err_irq_o = (state_q == ST_RESP) && errFlag_q;
  assign err_cnt_o = errCnt_q;

endmodule
